dvi_video_controller: RTL and testbench



---
 rtl/dvi_video_controller_pkg.sv | 67 ++++++
 rtl/video_timing_gen.sv | 89 ++++++++
 rtl/video_timing_params.vh | 29 ++
 rtl/dvi_video_controller.sv | 116 +++++++++++
 tb/tb_dvi_video_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_video_controller_pkg.sv
// Shared types, timing defaults and IDF=3 pixel packing for the DVI video controller.
package dvi_video_controller_pkg;

`include "video_timing_params.vh"

   localparam int unsigned XGA_H_SYNC    = `VTP_XGA_H_SYNC;
   localparam int unsigned XGA_H_BACK    = `VTP_XGA_H_BACK;
   localparam int unsigned XGA_H_VISIBLE = `VTP_XGA_H_VISIBLE;
   localparam int unsigned XGA_H_FRONT   = `VTP_XGA_H_FRONT;
   localparam int unsigned XGA_V_SYNC    = `VTP_XGA_V_SYNC;
   localparam int unsigned XGA_V_BACK    = `VTP_XGA_V_BACK;
   localparam int unsigned XGA_V_VISIBLE = `VTP_XGA_V_VISIBLE;
   localparam int unsigned XGA_V_FRONT   = `VTP_XGA_V_FRONT;

   localparam int unsigned RISE_R_MSB   = `VTP_RISE_R_MSB;
   localparam int unsigned RISE_R_LSB   = `VTP_RISE_R_LSB;
   localparam int unsigned RISE_GHI_MSB = `VTP_RISE_GHI_MSB;
   localparam int unsigned RISE_GHI_LSB = `VTP_RISE_GHI_LSB;
   localparam int unsigned FALL_GLO_MSB = `VTP_FALL_GLO_MSB;
   localparam int unsigned FALL_GLO_LSB = `VTP_FALL_GLO_LSB;
   localparam int unsigned FALL_B_MSB   = `VTP_FALL_B_MSB;
   localparam int unsigned FALL_B_LSB   = `VTP_FALL_B_LSB;

   localparam logic SYNC_ACTIVE_LOW  = `VTP_SYNC_ACTIVE_LOW;
   localparam logic SYNC_ACTIVE_HIGH = `VTP_SYNC_ACTIVE_HIGH;

   localparam int unsigned DDR_W = 12;

   typedef struct packed {
      logic [4:0] r;
      logic [4:0] g;
      logic [4:0] b;
   } rgb555_t;

   typedef enum logic [1:0] {
      HSync,
      HBack,
      HVisible,
      HFront
   } h_region_e;

   typedef enum logic [1:0] {
      VSync,
      VBack,
      VActive,
      VFront
   } v_region_e;

   // Rising-edge half: R and the top two G bits; unused bits stay zero.
   function automatic logic [DDR_W-1:0] idf3_rise(input rgb555_t px);
      logic [DDR_W-1:0] w;
      w = '0;
      w[RISE_R_MSB:RISE_R_LSB]     = px.r;
      w[RISE_GHI_MSB:RISE_GHI_LSB] = px.g[4:3];
      return w;
   endfunction

   // Falling-edge half: low three G bits and B.
   function automatic logic [DDR_W-1:0] idf3_fall(input rgb555_t px);
      logic [DDR_W-1:0] w;
      w = '0;
      w[FALL_GLO_MSB:FALL_GLO_LSB] = px.g[2:0];
      w[FALL_B_MSB:FALL_B_LSB]     = px.b;
      return w;
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running h/v raster counters with line/frame region decode.
module video_timing_gen
   import dvi_video_controller_pkg::*;
#(
   parameter int unsigned H_SYNC    = XGA_H_SYNC,
   parameter int unsigned H_BACK    = XGA_H_BACK,
   parameter int unsigned H_VISIBLE = XGA_H_VISIBLE,
   parameter int unsigned H_FRONT   = XGA_H_FRONT,
   parameter int unsigned V_SYNC    = XGA_V_SYNC,
   parameter int unsigned V_BACK    = XGA_V_BACK,
   parameter int unsigned V_VISIBLE = XGA_V_VISIBLE,
   parameter int unsigned V_FRONT   = XGA_V_FRONT
) (
   input  logic clk,
   input  logic reset_b,
   output logic vis_next,
   output logic hs_next,
   output logic vs_next,
   output logic frame_origin,
   output logic frame_last
);

   localparam int unsigned HT = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int unsigned VT = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
   localparam int unsigned HW = (HT > 1) ? $clog2(HT) : 1;
   localparam int unsigned VW = (VT > 1) ? $clog2(VT) : 1;

   localparam int unsigned H_BACK_START  = H_SYNC;
   localparam int unsigned H_VIS_START   = H_SYNC + H_BACK;
   localparam int unsigned H_FRONT_START = H_VIS_START + H_VISIBLE;
   localparam int unsigned V_BACK_START  = V_SYNC;
   localparam int unsigned V_ACT_START   = V_SYNC + V_BACK;
   localparam int unsigned V_FRONT_START = V_ACT_START + V_VISIBLE;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap;
   h_region_e     h_region;
   v_region_e     v_region;

   assign h_wrap = (h_cnt == HW'(HT - 1));
   assign v_wrap = (v_cnt == VW'(VT - 1));

   // Pixel and line counters; they run regardless of video enable.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Position within the line.
   always_comb begin
      h_region = HFront;
      if (h_cnt < HW'(H_BACK_START)) begin
         h_region = HSync;
      end else if (h_cnt < HW'(H_VIS_START)) begin
         h_region = HBack;
      end else if (h_cnt < HW'(H_FRONT_START)) begin
         h_region = HVisible;
      end
   end

   // Position within the frame.
   always_comb begin
      v_region = VFront;
      if (v_cnt < VW'(V_BACK_START)) begin
         v_region = VSync;
      end else if (v_cnt < VW'(V_ACT_START)) begin
         v_region = VBack;
      end else if (v_cnt < VW'(V_FRONT_START)) begin
         v_region = VActive;
      end
   end

   // HSYNC only on active lines so H, V and DE never overlap.
   assign vis_next     = (v_region == VActive) && (h_region == HVisible);
   assign hs_next      = (v_region == VActive) && (h_region == HSync);
   assign vs_next      = (v_region == VSync);
   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
   assign frame_last   = h_wrap && v_wrap;

endmodule

// File: rtl/video_timing_params.vh
// Raster defaults, IDF=3 DDR field layout and sync polarity encoding for the DVI path.
`ifndef VIDEO_TIMING_PARAMS_VH
`define VIDEO_TIMING_PARAMS_VH

// XGA 1024x768 @ 60 Hz, 65 MHz pixel clock
`define VTP_XGA_H_SYNC     136
`define VTP_XGA_H_BACK     160
`define VTP_XGA_H_VISIBLE  1024
`define VTP_XGA_H_FRONT    24
`define VTP_XGA_V_SYNC     6
`define VTP_XGA_V_BACK     29
`define VTP_XGA_V_VISIBLE  768
`define VTP_XGA_V_FRONT    3

// IDF=3 placement of RGB555 fields in the two 12-bit DDR halves
`define VTP_RISE_R_MSB     10
`define VTP_RISE_R_LSB     6
`define VTP_RISE_GHI_MSB   5
`define VTP_RISE_GHI_LSB   4
`define VTP_FALL_GLO_MSB   11
`define VTP_FALL_GLO_LSB   9
`define VTP_FALL_B_MSB     8
`define VTP_FALL_B_LSB     4

// Sync polarity encoding: value of the asserted sync level
`define VTP_SYNC_ACTIVE_LOW  1'b0
`define VTP_SYNC_ACTIVE_HIGH 1'b1

`endif

// File: rtl/dvi_video_controller.sv
// Raster timing, pixel fetch and IDF=3 DDR packing for the CH7301C DVI transmitter.
module dvi_video_controller
   import dvi_video_controller_pkg::*;
#(
   parameter int unsigned H_SYNC        = XGA_H_SYNC,
   parameter int unsigned H_BACK        = XGA_H_BACK,
   parameter int unsigned H_VISIBLE     = XGA_H_VISIBLE,
   parameter int unsigned H_FRONT       = XGA_H_FRONT,
   parameter int unsigned V_SYNC        = XGA_V_SYNC,
   parameter int unsigned V_BACK        = XGA_V_BACK,
   parameter int unsigned V_VISIBLE     = XGA_V_VISIBLE,
   parameter int unsigned V_FRONT       = XGA_V_FRONT,
   parameter logic        SYNC_POLARITY = SYNC_ACTIVE_LOW
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             enable,
   input  logic [14:0]      pixel_data,
   input  logic             pixel_valid,
   output logic             pixel_ready,
   output logic [DDR_W-1:0] dvi_data_rise,
   output logic [DDR_W-1:0] dvi_data_fall,
   output logic             dvi_de,
   output logic             dvi_h,
   output logic             dvi_v,
   output logic             frame_start,
   output logic             underflow,
   input  logic             underflow_clear
);

   localparam logic SYNC_ON  = SYNC_POLARITY;
   localparam logic SYNC_OFF = ~SYNC_POLARITY;

   logic    vis_next;
   logic    hs_next;
   logic    vs_next;
   logic    frame_origin;
   logic    frame_last;
   logic    running;
   logic    starved;
   rgb555_t px;

   video_timing_gen #(
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT)
   ) u_timing (
      .clk          (clk),
      .reset_b      (reset_b),
      .vis_next     (vis_next),
      .hs_next      (hs_next),
      .vs_next      (vs_next),
      .frame_origin (frame_origin),
      .frame_last   (frame_last)
   );

   assign px          = rgb555_t'(pixel_data);
   assign pixel_ready = vis_next & running;
   assign starved     = pixel_ready & ~pixel_valid;

   // Latch enable on the edge into h=0,v=0 so it holds for the whole frame. Counters start at
   // the origin out of reset, so that first frame sees running=0 and stays blank.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         running <= 1'b0;
      end else if (frame_last) begin
         running <= enable;
      end
   end

   // Registered sync, DE and frame marker, one cycle behind the counters.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         dvi_h       <= SYNC_OFF;
         dvi_v       <= SYNC_OFF;
         dvi_de      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         dvi_h       <= hs_next ? SYNC_ON : SYNC_OFF;
         dvi_v       <= vs_next ? SYNC_ON : SYNC_OFF;
         dvi_de      <= pixel_ready;
         frame_start <= frame_origin;
      end
   end

   // Pixel packing; a starved DE slot or any blank cycle drives black.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         dvi_data_rise <= '0;
         dvi_data_fall <= '0;
      end else if (pixel_ready && pixel_valid) begin
         dvi_data_rise <= idf3_rise(px);
         dvi_data_fall <= idf3_fall(px);
      end else begin
         dvi_data_rise <= '0;
         dvi_data_fall <= '0;
      end
   end

   // Sticky underflow; a new starvation wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         underflow <= 1'b0;
      end else if (starved) begin
         underflow <= 1'b1;
      end else if (underflow_clear) begin
         underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dvi_video_controller.sv
// Directed bench: both sync polarities side by side against a cycle model and scoreboard.
module tb_dvi_video_controller;

   localparam int HS = 2, HB = 2, HV = 4, HF = 2;
   localparam int VS = 1, VB = 1, VV = 2, VF = 1;
   localparam int HT = HS + HB + HV + HF;
   localparam int VT = VS + VB + VV + VF;

   logic        clk;
   logic        reset_b;
   logic        enable;
   logic        pixel_valid;
   logic        underflow_clear;
   logic [14:0] pixel_data;

   logic        rdy0, de0, h0, v0, fs0, uf0;
   logic        rdy1, de1, h1, v1, fs1, uf1;
   logic [11:0] rise0, fall0, rise1, fall1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dvi_video_controller #(
      .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF),
      .SYNC_POLARITY(1'b0)
   ) u_dut0 (
      .clk(clk), .reset_b(reset_b), .enable(enable), .pixel_data(pixel_data),
      .pixel_valid(pixel_valid), .pixel_ready(rdy0), .dvi_data_rise(rise0),
      .dvi_data_fall(fall0), .dvi_de(de0), .dvi_h(h0), .dvi_v(v0),
      .frame_start(fs0), .underflow(uf0), .underflow_clear(underflow_clear)
   );

   dvi_video_controller #(
      .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF),
      .SYNC_POLARITY(1'b1)
   ) u_dut1 (
      .clk(clk), .reset_b(reset_b), .enable(enable), .pixel_data(pixel_data),
      .pixel_valid(pixel_valid), .pixel_ready(rdy1), .dvi_data_rise(rise1),
      .dvi_data_fall(fall1), .dvi_de(de1), .dvi_h(h1), .dvi_v(v1),
      .frame_start(fs1), .underflow(uf1), .underflow_clear(underflow_clear)
   );

   typedef struct packed {
      logic        de;
      logic        h;   // asserted, polarity-free
      logic        v;
      logic        fs;
      logic        uf;
      logic [11:0] rise;
      logic [11:0] fall;
   } exp_t;

   exp_t sb[$];

   int   m_h, m_v;
   logic m_run, m_uf;
   int   n_vec, n_err;
   int   de_seen, take_seen, h_seen, v_seen;
   logic [11:0] last_rise, last_fall;

   function automatic logic [11:0] exp_rise(input logic [14:0] p);
      return {1'b0, p[14:10], p[9:8], 4'b0000};
   endfunction

   function automatic logic [11:0] exp_fall(input logic [14:0] p);
      return {p[7:5], p[4:0], 4'b0000};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk1("rst_de0", de0, 1'b0);      chk1("rst_de1", de1, 1'b0);
      chk1("rst_h0", h0, 1'b1);        chk1("rst_h1", h1, 1'b0);
      chk1("rst_v0", v0, 1'b1);        chk1("rst_v1", v1, 1'b0);
      chk1("rst_rdy0", rdy0, 1'b0);    chk1("rst_rdy1", rdy1, 1'b0);
      chk1("rst_fs0", fs0, 1'b0);      chk1("rst_uf0", uf0, 1'b0);
      chk12("rst_rise0", rise0, 12'h000);
      chk12("rst_fall0", fall0, 12'h000);
   endtask

   task automatic clr_counts();
      de_seen = 0; take_seen = 0; h_seen = 0; v_seen = 0;
   endtask

   // One pixel clock: predict from the model, push, clock, pop and compare.
   task automatic step();
      exp_t e;
      logic act, vis, rdy;
      int   busy;
      #1;
      act = (m_v >= VS + VB) && (m_v < VS + VB + VV);
      vis = act && (m_h >= HS + HB) && (m_h < HS + HB + HV);
      rdy = vis && m_run;
      chk1("pixel_ready_pol0", rdy0, rdy);
      chk1("pixel_ready_pol1", rdy1, rdy);
      if (rdy0 && pixel_valid) take_seen++;
      e.de   = rdy;
      e.h    = act && (m_h < HS);
      e.v    = (m_v < VS);
      e.fs   = (m_h == 0) && (m_v == 0);
      e.rise = (rdy && pixel_valid) ? exp_rise(pixel_data) : 12'h000;
      e.fall = (rdy && pixel_valid) ? exp_fall(pixel_data) : 12'h000;
      e.uf   = (rdy && !pixel_valid) ? 1'b1 : (underflow_clear ? 1'b0 : m_uf);
      sb.push_back(e);
      @(posedge clk);
      if (m_h == HT - 1 && m_v == VT - 1) m_run = enable;
      m_uf = e.uf;
      if (m_h == HT - 1) begin
         m_h = 0;
         m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
         m_h++;
      end
      #1;
      e = sb.pop_front();
      chk1("de_pol0", de0, e.de);      chk1("de_pol1", de1, e.de);
      chk1("h_pol0", h0, ~e.h);        chk1("h_pol1", h1, e.h);
      chk1("v_pol0", v0, ~e.v);        chk1("v_pol1", v1, e.v);
      chk1("fs_pol0", fs0, e.fs);      chk1("fs_pol1", fs1, e.fs);
      chk1("uf_pol0", uf0, e.uf);      chk1("uf_pol1", uf1, e.uf);
      chk12("rise_pol0", rise0, e.rise);
      chk12("fall_pol0", fall0, e.fall);
      chk12("rise_pol1", rise1, e.rise);
      chk12("fall_pol1", fall1, e.fall);
      busy = int'(!h0) + int'(!v0) + int'(de0);
      chk1("excl_pol0", busy <= 1, 1'b1);
      busy = int'(h1) + int'(v1) + int'(de1);
      chk1("excl_pol1", busy <= 1, 1'b1);
      if (de0) begin
         de_seen++;
         last_rise = rise0;
         last_fall = fall0;
      end
      if (!h0) h_seen++;
      if (!v0) v_seen++;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset_b = 1'b0; enable = 1'b0; pixel_valid = 1'b1; underflow_clear = 1'b0;
      pixel_data = {5'h1F, 5'h15, 5'h0A};
      m_h = 0; m_v = 0; m_run = 1'b0; m_uf = 1'b0;
      last_rise = 12'h000; last_fall = 12'h000;

      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      reset_b = 1'b1;

      // Frame 1: blank; enable raised mid-frame only takes effect next frame
      clr_counts();
      for (int i = 0; i < HT * VT; i++) begin
         if (i == 30) enable = 1'b1;
         step();
      end
      chk_int("f1_v_cycles", v_seen, 10);
      chk_int("f1_h_cycles", h_seen, 4);
      chk_int("f1_de_cycles", de_seen, 0);
      chk_int("f1_taken", take_seen, 0);

      // Frame 2: streaming fixed colour
      clr_counts();
      for (int i = 0; i < HT * VT; i++) step();
      chk_int("f2_de_cycles", de_seen, 8);
      chk_int("f2_taken", take_seen, 8);
      chk_int("f2_h_cycles", h_seen, 4);
      chk12("f2_rise_word", last_rise, 12'h7E0);
      chk12("f2_fall_word", last_fall, 12'hAA0);
      chk1("f2_underflow", uf0, 1'b0);

      // Frame 3: underflow, clear racing a new underflow, then a lone clear
      clr_counts();
      pixel_data = {5'h03, 5'h1C, 5'h11};
      for (int i = 0; i < HT * VT; i++) begin
         pixel_valid     = !(i == 26 || i == 35);
         underflow_clear = (i == 35 || i == 40);
         step();
         if (i == 26) begin
            chk1("uf_slot_de", de0, 1'b1);
            chk12("uf_slot_rise", rise0, 12'h000);
            chk12("uf_slot_fall", fall0, 12'h000);
         end
         if (i == 26 || i == 35) chk1("uf_held", uf0, 1'b1);
         if (i == 40) chk1("uf_cleared", uf0, 1'b0);
      end
      pixel_valid = 1'b1; underflow_clear = 1'b0;
      chk_int("f3_de_cycles", de_seen, 8);
      chk_int("f3_taken", take_seen, 6);

      // Frame 4: enable dropped mid-frame, frame still completes
      clr_counts();
      for (int i = 0; i < HT * VT; i++) begin
         if (i == 20) enable = 1'b0;
         step();
      end
      chk_int("f4_taken", take_seen, 8);

      // Frame 5: blank; enable back on for frame 6
      clr_counts();
      for (int i = 0; i < HT * VT; i++) begin
         if (i == 10) enable = 1'b1;
         step();
      end
      chk_int("f5_de_cycles", de_seen, 0);
      chk_int("f5_taken", take_seen, 0);

      // Frame 6: async reset at h=6 of the first active line
      for (int i = 0; i < 26; i++) step();
      chk_int("pre_reset_h", m_h, 6);
      reset_b = 1'b0;
      #1;
      chk_reset();
      @(posedge clk);
      #1;
      reset_b = 1'b1;
      m_h = 0; m_v = 0; m_run = 1'b0; m_uf = 1'b0;

      // Frame 7: first frame after reset is blank despite enable=1
      clr_counts();
      for (int i = 0; i < HT * VT; i++) begin
         step();
         if (i == 0) chk1("fs_after_reset", fs0, 1'b1);
      end
      chk_int("f7_de_cycles", de_seen, 0);
      chk_int("f7_taken", take_seen, 0);
      chk_int("f7_v_cycles", v_seen, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
